// File: rtl/dpram_loader_pkg.sv
// Shared types and helpers for the byte-stream dpram loader.
//   state_e  : loader FSM states
//   bytes_of : number of bytes packed into one RAM word of the given width
package dpram_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_VERIFY,
    ST_FIN
  } state_e;

  function automatic int unsigned bytes_of(input int unsigned width);
    return width / 8;
  endfunction

endpackage

// File: rtl/dpram_loader_pack.sv
// Little-endian byte packer: collects stream bytes into a WIDTH-bit word.
// Byte k of a word lands in bits [8k+7:8k]; bytes not yet received read as 0.
//   clk_sys   in   system clock
//   reset_n   in   asynchronous active-low reset
//   clear_i   in   empty the word buffer and restart at byte 0
//   accept_i  in   byte_i transfers this cycle
//   byte_i    in   stream byte
//   word_o    out  packed word (zero-padded above the received bytes)
//   full_o    out  the next accepted byte completes the word
module dpram_loader_pack
  import dpram_loader_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             clear_i,
  input  logic             accept_i,
  input  logic [7:0]       byte_i,
  output logic [WIDTH-1:0] word_o,
  output logic             full_o
);

  localparam int unsigned BYTES = bytes_of(WIDTH);
  localparam int unsigned CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;

  assign full_o = (cnt_q == CW'(BYTES - 1));
  assign word_o = word_q;

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clear_i) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (accept_i) begin
      for (int k = 0; k < BYTES; k++) begin
        if (cnt_q == CW'(k)) word_d[8*k +: 8] = byte_i;
      end
      cnt_d = full_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/dpram_loader.sv
// Byte-stream download engine for a dual-port RAM port: packs stream bytes
// into words, writes them from BASE_ADDR upward, then reads the region back
// and compares XOR checksums of written and returned data.
//   clk_sys, reset_n           clock, asynchronous active-low reset
//   start                      1-cycle pulse, begins a load when idle
//   dl_valid/dl_data/dl_last   byte stream in; dl_ready out
//   ram_address/ram_data/ram_we/ram_ce/ram_q   RAM port (loader is initiator)
//   busy, done, error          status; error sticky until next start
//   words_written              words written by the last load
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | accepting bytes into the pack buffer
// WRITE  | one-cycle RAM write of the packed word
// VERIFY | back-to-back read-back, XOR of returned data
// FIN    | one-cycle done pulse
module dpram_loader
  import dpram_loader_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned WIDTHAD   = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               start,
  input  logic               dl_valid,
  input  logic [7:0]         dl_data,
  input  logic               dl_last,
  output logic               dl_ready,
  output logic [WIDTHAD-1:0] ram_address,
  output logic [WIDTH-1:0]   ram_data,
  output logic               ram_we,
  output logic               ram_ce,
  input  logic [WIDTH-1:0]   ram_q,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [WIDTHAD:0]   words_written
);

  localparam logic [WIDTHAD-1:0] BASE     = WIDTHAD'(BASE_ADDR);
  localparam logic [WIDTHAD-1:0] TOP_ADDR = '1;

  state_e             state_q, state_d;
  logic [WIDTHAD:0]   ww_q, ww_d, rd_cnt_q, rd_cnt_d;
  logic [WIDTH-1:0]   wxor_q, wxor_d, rxor_q, rxor_d;
  logic               err_q, err_d, last_q, last_d, rd_vld_q, rd_vld_d;
  logic               accept, pack_clear, word_full;
  logic [WIDTH-1:0]   word, rxor_final;
  logic [WIDTHAD-1:0] wr_addr, rd_addr;

  dpram_loader_pack #(.WIDTH(WIDTH)) u_pack (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .clear_i  (pack_clear),
    .accept_i (accept),
    .byte_i   (dl_data),
    .word_o   (word),
    .full_o   (word_full)
  );

  assign wr_addr = BASE + ww_q[WIDTHAD-1:0];
  assign rd_addr = BASE + rd_cnt_q[WIDTHAD-1:0];
  // Read-back checksum including the return arriving this cycle.
  assign rxor_final = rd_vld_q ? (rxor_q ^ ram_q) : rxor_q;

  assign error         = err_q;
  assign words_written = ww_q;

  always_comb begin
    state_d     = state_q;
    ww_d        = ww_q;
    rd_cnt_d    = rd_cnt_q;
    wxor_d      = wxor_q;
    rxor_d      = rxor_q;
    err_d       = err_q;
    last_d      = last_q;
    rd_vld_d    = 1'b0;
    dl_ready    = 1'b0;
    ram_we      = 1'b0;
    ram_ce      = 1'b0;
    ram_address = BASE;
    ram_data    = '0;
    busy        = 1'b1;
    done        = 1'b0;
    accept      = 1'b0;
    pack_clear  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d    = ST_LOAD;
          ww_d       = '0;
          rd_cnt_d   = '0;
          wxor_d     = '0;
          rxor_d     = '0;
          err_d      = 1'b0;
          last_d     = 1'b0;
          pack_clear = 1'b1;
        end
      end
      ST_LOAD: begin
        dl_ready = 1'b1;
        if (dl_valid) begin
          accept = 1'b1;
          // A last byte that also fills the word still gives one write.
          if (word_full || dl_last) begin
            state_d = ST_WRITE;
            last_d  = dl_last;
          end
        end
      end
      ST_WRITE: begin
        ram_we      = 1'b1;
        ram_ce      = 1'b1;
        ram_address = wr_addr;
        ram_data    = word;
        wxor_d      = wxor_q ^ word;
        ww_d        = ww_q + 1'b1;
        pack_clear  = 1'b1;
        if (last_q) begin
          state_d = ST_VERIFY;
        end else if (wr_addr == TOP_ADDR) begin
          // No wrap to address 0: stop and flag the overflow.
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_VERIFY: begin
        ram_address = rd_addr;
        if (rd_vld_q) rxor_d = rxor_final;
        if (rd_cnt_q != ww_q) begin
          ram_ce   = 1'b1;
          rd_vld_d = 1'b1;
          rd_cnt_d = rd_cnt_q + 1'b1;
        end else begin
          // All reads issued; this cycle collects the final return.
          state_d = ST_FIN;
          if (rxor_final != wxor_q) err_d = 1'b1;
        end
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      ww_q     <= '0;
      rd_cnt_q <= '0;
      wxor_q   <= '0;
      rxor_q   <= '0;
      err_q    <= 1'b0;
      last_q   <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ww_q     <= ww_d;
      rd_cnt_q <= rd_cnt_d;
      wxor_q   <= wxor_d;
      rxor_q   <= rxor_d;
      err_q    <= err_d;
      last_q   <= last_d;
      rd_vld_q <= rd_vld_d;
    end
  end

endmodule

// File: tb/tb_dpram_loader.sv
// Bench for dpram_loader: four loader instances of different geometry share one
// stream driver (selected by sel), each paired with a behavioural RAM.
module tb_dpram_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_g, valid_g, last_g;
  logic [7:0]  data_g;
  int          sel;
  logic        corrupt_en;

  logic [3:0]  ready_a, we_a, ce_a, busy_a, done_a, err_a;
  logic [31:0] addr_a [4];
  logic [31:0] data_a [4];
  logic [31:0] ww_a   [4];
  logic [31:0] q_a    [4];
  logic [31:0] mem    [4][1024];

  logic [63:0] wlog      [$];
  logic [63:0] ref_log   [$];
  logic [7:0]  stim_q    [$];
  logic [31:0] exp_words [$];

  int checks   = 0;
  int failures = 0;

  int b_of    [4] = '{1, 1, 2, 4};
  int base_of [4] = '{0, 0, 0, 1};
  int cap_of  [4] = '{1024, 4, 1024, 15};

  logic [9:0]  a0, a2;
  logic [1:0]  a1;
  logic [3:0]  a3;
  logic [7:0]  d0, d1;
  logic [15:0] d2;
  logic [31:0] d3;
  logic [10:0] w0, w2;
  logic [2:0]  w1;
  logic [4:0]  w3;

  dpram_loader #(.WIDTH(8), .WIDTHAD(10), .BASE_ADDR(0)) u0 (
    .clk_sys(clk), .reset_n(rst_n), .start(start_g && sel == 0),
    .dl_valid(valid_g && sel == 0), .dl_data(data_g), .dl_last(last_g),
    .dl_ready(ready_a[0]), .ram_address(a0), .ram_data(d0), .ram_we(we_a[0]),
    .ram_ce(ce_a[0]), .ram_q(q_a[0][7:0]), .busy(busy_a[0]), .done(done_a[0]),
    .error(err_a[0]), .words_written(w0));

  dpram_loader #(.WIDTH(8), .WIDTHAD(2), .BASE_ADDR(0)) u1 (
    .clk_sys(clk), .reset_n(rst_n), .start(start_g && sel == 1),
    .dl_valid(valid_g && sel == 1), .dl_data(data_g), .dl_last(last_g),
    .dl_ready(ready_a[1]), .ram_address(a1), .ram_data(d1), .ram_we(we_a[1]),
    .ram_ce(ce_a[1]), .ram_q(q_a[1][7:0]), .busy(busy_a[1]), .done(done_a[1]),
    .error(err_a[1]), .words_written(w1));

  dpram_loader #(.WIDTH(16), .WIDTHAD(10), .BASE_ADDR(0)) u2 (
    .clk_sys(clk), .reset_n(rst_n), .start(start_g && sel == 2),
    .dl_valid(valid_g && sel == 2), .dl_data(data_g), .dl_last(last_g),
    .dl_ready(ready_a[2]), .ram_address(a2), .ram_data(d2), .ram_we(we_a[2]),
    .ram_ce(ce_a[2]), .ram_q(q_a[2][15:0]), .busy(busy_a[2]), .done(done_a[2]),
    .error(err_a[2]), .words_written(w2));

  dpram_loader #(.WIDTH(32), .WIDTHAD(4), .BASE_ADDR(1)) u3 (
    .clk_sys(clk), .reset_n(rst_n), .start(start_g && sel == 3),
    .dl_valid(valid_g && sel == 3), .dl_data(data_g), .dl_last(last_g),
    .dl_ready(ready_a[3]), .ram_address(a3), .ram_data(d3), .ram_we(we_a[3]),
    .ram_ce(ce_a[3]), .ram_q(q_a[3]), .busy(busy_a[3]), .done(done_a[3]),
    .error(err_a[3]), .words_written(w3));

  assign addr_a[0] = 32'(a0);
  assign addr_a[1] = 32'(a1);
  assign addr_a[2] = 32'(a2);
  assign addr_a[3] = 32'(a3);
  assign data_a[0] = 32'(d0);
  assign data_a[1] = 32'(d1);
  assign data_a[2] = 32'(d2);
  assign data_a[3] = d3;
  assign ww_a[0]   = 32'(w0);
  assign ww_a[1]   = 32'(w1);
  assign ww_a[2]   = 32'(w2);
  assign ww_a[3]   = 32'(w3);

  // Behavioural single-port view of each dpram; read data one cycle after issue.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (ce_a[k]) begin
        if (we_a[k]) mem[k][addr_a[k][9:0]] <= data_a[k];
        q_a[k] <= mem[k][addr_a[k][9:0]];
      end
    end
    if (corrupt_en && we_a[0] && addr_a[0] == 32'd3) mem[0][2] <= mem[0][2] ^ 32'hFF;
    if (we_a[sel]) wlog.push_back({addr_a[sel], data_a[sel]});
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives stim_q into instance k with random gaps up to max_gap; pulses start
  // again at loop cycle start_at (while busy). Returns once done is seen.
  task automatic run_stream(input int k, input bit use_last, input int max_gap,
                            input int start_at, output int n_acc, output bit got_err,
                            output int got_ww);
    int gap, n;
    bit got_done;
    n = stim_q.size();
    wlog.delete();
    sel = k;
    n_acc = 0; got_done = 1'b0; got_err = 1'b0; got_ww = 0;
    @(negedge clk); start_g = 1'b1;
    @(negedge clk); start_g = 1'b0;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    for (int cyc = 0; cyc < 600 && !got_done; cyc++) begin
      if (done_a[k]) begin
        got_done = 1'b1;
        got_err  = err_a[k];
        got_ww   = int'(ww_a[k]);
      end else begin
        start_g = (cyc == start_at);
        if (n_acc < n && gap == 0) begin
          valid_g = 1'b1;
          data_g  = stim_q[n_acc];
          last_g  = use_last && (n_acc == n - 1);
        end else begin
          valid_g = 1'b0;
          last_g  = 1'b0;
          if (gap > 0) gap--;
        end
        if (valid_g && ready_a[k]) begin
          n_acc++;
          gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        end
        @(negedge clk);
      end
    end
    valid_g = 1'b0; last_g = 1'b0; start_g = 1'b0;
    chk("done_seen", 64'(got_done), 64'd1);
    if (got_done) begin
      @(negedge clk);
      chk("done_pulse_width", 64'(done_a[k]), 64'd0);
      chk("busy_after_done", 64'(busy_a[k]), 64'd0);
      chk("error_sticky", 64'(err_a[k]), 64'(got_err));
    end
  endtask

  // Reference: words are the stream cut into groups of BYTES, byte j of a group
  // weighted by 256**j; the load stops with an error when the region runs out.
  task automatic model(input int k, input bit use_last, output int e_ww,
                       output bit e_err, output int e_acc);
    int n, nw, bpw, cap;
    logic [31:0] w;
    n = stim_q.size(); bpw = b_of[k]; cap = cap_of[k];
    nw = (n + bpw - 1) / bpw;
    exp_words.delete();
    if (!use_last || nw > cap) begin
      e_ww = cap; e_err = 1'b1; e_acc = cap * bpw;
    end else begin
      e_ww = nw; e_err = 1'b0; e_acc = n;
    end
    for (int i = 0; i < e_ww; i++) begin
      w = '0;
      for (int j = 0; j < bpw; j++)
        if (i * bpw + j < n) w = w + (32'(stim_q[i*bpw+j]) << (8 * j));
      exp_words.push_back(w);
    end
  endtask

  task automatic check_log(input int k);
    chk("log_nwrites", 64'(wlog.size()), 64'(exp_words.size()));
    for (int i = 0; i < wlog.size() && i < exp_words.size(); i++) begin
      chk("log_addr", 64'(wlog[i][63:32]), 64'(base_of[k] + i));
      chk("log_data", 64'(wlog[i][31:0]), 64'(exp_words[i]));
      chk("ram_content", 64'(mem[k][base_of[k]+i]), 64'(exp_words[i]));
    end
  endtask

  typedef struct packed {
    int          inst;
    int          n;
    logic [63:0] bytes;
    logic        use_last;
    int          exp_ww;
    logic        exp_err;
    int          exp_acc;
    logic [31:0] exp_w0;
    logic [31:0] exp_w1;
  } vec_t;

  vec_t vecs [7];

  initial begin : main
    int n_acc, got_ww, e_ww, e_acc, n, k;
    bit got_err, e_err;
    logic [63:0] bv;

    vecs[0] = '{inst:0, n:4, bytes:64'h44332211, use_last:1, exp_ww:4, exp_err:0,
                exp_acc:4, exp_w0:32'h11, exp_w1:32'h22};
    vecs[1] = '{inst:2, n:3, bytes:64'hCCBBAA, use_last:1, exp_ww:2, exp_err:0,
                exp_acc:3, exp_w0:32'hBBAA, exp_w1:32'h00CC};
    vecs[2] = '{inst:1, n:6, bytes:64'h060504030201, use_last:0, exp_ww:4, exp_err:1,
                exp_acc:4, exp_w0:32'h01, exp_w1:32'h02};
    vecs[3] = '{inst:3, n:4, bytes:64'h44332211, use_last:1, exp_ww:1, exp_err:0,
                exp_acc:4, exp_w0:32'h44332211, exp_w1:32'h0};
    vecs[4] = '{inst:1, n:4, bytes:64'hA4A3A2A1, use_last:1, exp_ww:4, exp_err:0,
                exp_acc:4, exp_w0:32'hA1, exp_w1:32'hA2};
    vecs[5] = '{inst:2, n:1, bytes:64'h5A, use_last:1, exp_ww:1, exp_err:0,
                exp_acc:1, exp_w0:32'h005A, exp_w1:32'h0};
    vecs[6] = '{inst:3, n:5, bytes:64'h0504030201, use_last:1, exp_ww:2, exp_err:0,
                exp_acc:5, exp_w0:32'h04030201, exp_w1:32'h00000005};

    rst_n = 1'b0; start_g = 1'b0; valid_g = 1'b0; last_g = 1'b0; data_g = 8'h00;
    sel = 0; corrupt_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_ready", 64'(ready_a), 64'd0);
    chk("rst_we_ce", 64'({we_a, ce_a}), 64'd0);
    chk("rst_addr_base", 64'(addr_a[3]), 64'd1);
    chk("rst_ww", 64'(ww_a[2]), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven directed loads.
    for (int v = 0; v < 7; v++) begin
      stim_q.delete();
      bv = vecs[v].bytes;
      for (int i = 0; i < vecs[v].n; i++) stim_q.push_back(bv[8*i +: 8]);
      k = vecs[v].inst;
      run_stream(k, vecs[v].use_last, 0, -1, n_acc, got_err, got_ww);
      chk("vec_ww", 64'(got_ww), 64'(vecs[v].exp_ww));
      chk("vec_err", 64'(got_err), 64'(vecs[v].exp_err));
      chk("vec_accepted", 64'(n_acc), 64'(vecs[v].exp_acc));
      chk("vec_nwrites", 64'(wlog.size()), 64'(vecs[v].exp_ww));
      for (int i = 0; i < wlog.size(); i++)
        chk("vec_addr", 64'(wlog[i][63:32]), 64'(base_of[k] + i));
      if (wlog.size() > 0) begin
        chk("vec_w0", 64'(wlog[0][31:0]), 64'(vecs[v].exp_w0));
        chk("vec_ram_w0", 64'(mem[k][base_of[k]]), 64'(vecs[v].exp_w0));
      end
      if (vecs[v].exp_ww >= 2 && wlog.size() >= 2)
        chk("vec_w1", 64'(wlog[1][31:0]), 64'(vecs[v].exp_w1));
    end

    // Corrupt RAM[2] after the last write, before its read-back.
    stim_q.delete();
    stim_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    corrupt_en = 1'b1;
    run_stream(0, 1'b1, 0, -1, n_acc, got_err, got_ww);
    corrupt_en = 1'b0;
    chk("corrupt_err", 64'(got_err), 64'd1);
    chk("corrupt_ww", 64'(got_ww), 64'd4);

    // Gapless reference vs gapped run with a stray start mid-load.
    stim_q.delete();
    for (int i = 0; i < 10; i++) stim_q.push_back(8'($urandom));
    model(3, 1'b1, e_ww, e_err, e_acc);
    run_stream(3, 1'b1, 0, -1, n_acc, got_err, got_ww);
    chk("gapless_ww", 64'(got_ww), 64'd3);
    chk("gapless_err", 64'(got_err), 64'd0);
    check_log(3);
    ref_log = wlog;
    run_stream(3, 1'b1, 3, 5, n_acc, got_err, got_ww);
    chk("gapped_ww", 64'(got_ww), 64'd3);
    chk("gapped_err", 64'(got_err), 64'd0);
    chk("gapped_nwrites", 64'(wlog.size()), 64'(ref_log.size()));
    for (int i = 0; i < wlog.size() && i < ref_log.size(); i++)
      chk("gapped_vs_gapless", wlog[i], ref_log[i]);

    // Randomised loads against the reference model.
    for (int t = 0; t < 8; t++) begin
      k = (t % 2 == 1) ? 1 : 3;
      n = int'($urandom_range((k == 3) ? 40 : 8, 1));
      stim_q.delete();
      for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom));
      model(k, 1'b1, e_ww, e_err, e_acc);
      run_stream(k, 1'b1, 3, -1, n_acc, got_err, got_ww);
      chk("rand_ww", 64'(got_ww), 64'(e_ww));
      chk("rand_err", 64'(got_err), 64'(e_err));
      chk("rand_accepted", 64'(n_acc), 64'(e_acc));
      check_log(k);
    end

    // Reset after one of two bytes of a 16-bit word.
    sel = 2;
    wlog.delete();
    @(negedge clk); start_g = 1'b1;
    @(negedge clk); start_g = 1'b0; valid_g = 1'b1; data_g = 8'hAA;
    @(negedge clk); valid_g = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", 64'(ready_a[2]), 64'd0);
    chk("midrst_we_ce", 64'({we_a[2], ce_a[2]}), 64'd0);
    chk("midrst_busy_done_err", 64'({busy_a[2], done_a[2], err_a[2]}), 64'd0);
    chk("midrst_addr_data", 64'({addr_a[2], data_a[2]}), 64'd0);
    chk("midrst_ww", 64'(ww_a[2]), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_no_write", 64'(wlog.size()), 64'd0);
    stim_q.delete();
    stim_q = '{8'h12, 8'h34};
    run_stream(2, 1'b1, 0, -1, n_acc, got_err, got_ww);
    chk("postrst_ww", 64'(got_ww), 64'd1);
    chk("postrst_err", 64'(got_err), 64'd0);
    chk("postrst_nwrites", 64'(wlog.size()), 64'd1);
    if (wlog.size() > 0) chk("postrst_word", wlog[0], {32'd0, 32'h3412});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
